// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage RISC-V core.
//
// Drives the PC and pipeline-register write enables plus the IF/ID and ID/EX
// bubble flushes. Hazard and stall sources are resolved by a fixed priority.
// The whole pipe is frozen while a data-memory access or a multi-cycle MDU
// operation is outstanding. Saturating stall/flush performance counters and a
// sticky wait-timeout error flag are kept.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rstn          synchronous active-low reset
//   imem_ready    instruction fetch data valid this cycle
//   load_use      ID instruction depends on a load in EX
//   branch_taken  EX resolved a taken branch or jump
//   dmem_req      MEM stage has a data access (held stable while frozen)
//   dmem_ready    data memory completes the access this cycle
//   mdu_start     EX holds a multi-cycle mul/div (held stable while frozen)
//   mdu_done      MDU result valid this cycle
//   halt_req      debug halt request, level
//   cnt_clr       clears both performance counters
//   pc_wen .. memwb_wen      register write enables
//   ifid_flush, idex_flush   load a bubble into the register at the next edge
//   state         00 RUN, 01 DWAIT, 10 MWAIT, 11 HALT
//   err           sticky wait-timeout error
//   stall_cnt     cycles with pc_wen=0, saturating
//   flush_cnt     branch flush events, saturating

module pipe_ctrl #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 imem_ready,
    input  logic                 load_use,
    input  logic                 branch_taken,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    input  logic                 mdu_start,
    input  logic                 mdu_done,
    input  logic                 halt_req,
    input  logic                 cnt_clr,
    output logic                 pc_wen,
    output logic                 ifid_wen,
    output logic                 idex_wen,
    output logic                 exmem_wen,
    output logic                 memwb_wen,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic [1:0]           state,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StDwait = 2'b01,
        StMwait = 2'b10,
        StHalt  = 2'b11
    } state_e;

    // Last wait_cnt value before a timeout fires; unused when TIMEOUT is 0.
    localparam bit          TimeoutEn   = (TIMEOUT != 0);
    localparam logic [15:0] TimeoutLast = TimeoutEn ? 16'(TIMEOUT - 1) : 16'd0;

    state_e                 state_q, state_d;
    logic                   err_q, err_d;
    logic [15:0]            wait_cnt_q, wait_cnt_d;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;

    logic dmem_stall;
    logic mdu_stall;
    logic timeout_hit;
    logic pipe_go;       // hazard rules (branch / load-use / fetch) decide outputs
    logic branch_fire;   // branch flush rule selected this cycle

    assign dmem_stall  = dmem_req & ~dmem_ready;
    assign mdu_stall   = mdu_start & ~mdu_done;
    assign timeout_hit = TimeoutEn && (wait_cnt_q == TimeoutLast);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StRun;
            err_q       <= 1'b0;
            wait_cnt_q  <= 16'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StRun: begin
                // halt_req is only honoured here so an in-flight wait completes first
                if (halt_req) begin
                    state_d = StHalt;
                end else if (dmem_stall) begin
                    state_d    = StDwait;
                    wait_cnt_d = 16'd0;
                end else if (mdu_stall) begin
                    state_d    = StMwait;
                    wait_cnt_d = 16'd0;
                end
            end
            StDwait: begin
                if (dmem_ready) begin
                    if (mdu_stall) begin
                        state_d    = StMwait;
                        wait_cnt_d = 16'd0;
                    end else begin
                        state_d = StRun;
                    end
                end else if (timeout_hit) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            StMwait: begin
                if (mdu_done) begin
                    state_d = StRun;
                end else if (timeout_hit) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: begin
                // HALT: a timeout error pins the controller here until reset
                if (!err_q && !halt_req) begin
                    state_d = StRun;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_wen      = 1'b0;
        ifid_wen    = 1'b0;
        idex_wen    = 1'b0;
        exmem_wen   = 1'b0;
        memwb_wen   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_go     = 1'b0;
        branch_fire = 1'b0;
        if (!rstn) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            unique case (state_q)
                StRun:   pipe_go = ~halt_req & ~dmem_stall & ~mdu_stall;
                StDwait: pipe_go = dmem_ready & ~mdu_stall;
                StMwait: pipe_go = mdu_done;
                default: pipe_go = 1'b0;
            endcase
            if (pipe_go) begin
                if (branch_taken) begin
                    // Branch squashes the wrong-path instructions in IF/ID and ID/EX
                    pc_wen      = 1'b1;
                    ifid_wen    = 1'b1;
                    idex_wen    = 1'b1;
                    exmem_wen   = 1'b1;
                    memwb_wen   = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    branch_fire = 1'b1;
                end else if (load_use) begin
                    idex_wen   = 1'b1;
                    exmem_wen  = 1'b1;
                    memwb_wen  = 1'b1;
                    idex_flush = 1'b1;
                end else if (!imem_ready) begin
                    ifid_wen   = 1'b1;
                    idex_wen   = 1'b1;
                    exmem_wen  = 1'b1;
                    memwb_wen  = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    pc_wen    = 1'b1;
                    ifid_wen  = 1'b1;
                    idex_wen  = 1'b1;
                    exmem_wen = 1'b1;
                    memwb_wen = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters; clear wins over increment
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_wen && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (branch_fire && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    assign state     = state_q;
    assign err       = err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
